// File: rtl/dmx_rx.sv
// DMX512 receiver: synchronise and oversample rx, detect break/MAB,
// deserialise 8N2 slots, emit slot strobes and frame boundaries.
//
// Ports:
//   dmxclk      sole clock, OVERSAMPLE cycles per DMX bit
//   rst         asynchronous active-high reset
//   rx          raw DMX line (polarity set by INVERT)
//   slot_valid  one-cycle strobe, slot_index/slot_data valid
//   slot_index  0 = start code, 1..512 = channel slots
//   slot_data   received byte
//   frame_start pulse with slot 0 strobe
//   frame_end   pulse once per completed frame
//   slot_count  channel slots in last completed frame
//   error       pulse on MAB or framing violation
module dmx_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int BREAK_MIN  = 352,
  parameter int MAB_MIN    = 32,
  parameter bit INVERT     = 1'b1
) (
  input  logic       dmxclk,
  input  logic       rst,
  input  logic       rx,
  output logic       slot_valid,
  output logic [9:0] slot_index,
  output logic [7:0] slot_data,
  output logic       frame_start,
  output logic       frame_end,
  output logic [9:0] slot_count,
  output logic       error
);

  localparam logic MARK_RAW = INVERT ? 1'b0 : 1'b1;
  localparam int SW = $clog2(BREAK_MIN + 1);
  localparam int CMAX = (OVERSAMPLE > MAB_MIN)
                      ? OVERSAMPLE : MAB_MIN;
  localparam int CW = $clog2(CMAX + 1);
  localparam int HALF = OVERSAMPLE / 2 - 1;
  localparam int RUN9 = 9 * OVERSAMPLE;

  typedef enum logic [2:0] {
    WAIT_BREAK, BREAK, MAB, IDLE,
    START, DATA, STOP1, STOP2
  } state_t;

  state_t        state;
  logic [1:0]    sync;
  logic          space;
  logic [SW-1:0] spc_cnt;
  logic          brk_hit;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          from_mab;
  logic          open;
  logic [9:0]    cur_idx;

  assign space = INVERT ? sync[1] : ~sync[1];

  // Fires on the cycle the space run reaches BREAK_MIN (and while
  // saturated), overriding whatever the slot FSM is doing.
  assign brk_hit = space &&
                   (spc_cnt >= SW'(BREAK_MIN - 1));

  always_ff @(posedge dmxclk or posedge rst) begin
    if (rst) begin
      sync <= {2{MARK_RAW}};
    end else begin
      sync <= {sync[0], rx};
    end
  end

  always_ff @(posedge dmxclk or posedge rst) begin
    if (rst) begin
      spc_cnt <= '0;
    end else if (!space) begin
      spc_cnt <= '0;
    end else if (spc_cnt != SW'(BREAK_MIN)) begin
      spc_cnt <= spc_cnt + 1'b1;
    end
  end

  always_ff @(posedge dmxclk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_BREAK;
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      from_mab    <= 1'b0;
      open        <= 1'b0;
      cur_idx     <= '0;
      slot_valid  <= 1'b0;
      slot_index  <= '0;
      slot_data   <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      slot_count  <= '0;
      error       <= 1'b0;
    end else begin
      slot_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      error       <= 1'b0;
      if (brk_hit) begin
        state <= BREAK;
        if (open) begin
          frame_end  <= 1'b1;
          slot_count <= cur_idx - 10'd1;
          open       <= 1'b0;
        end
      end else begin
        unique case (state)
          // A frame may still be open here when an all-space slot
          // looked like the head of a break; if the line returns to
          // mark before a full break, that was a framing error.
          WAIT_BREAK: begin
            if (!space && open) begin
              error <= 1'b1;
              open  <= 1'b0;
            end
          end
          BREAK: begin
            if (!space) begin
              state <= MAB;
              cnt   <= CW'(1);
            end
          end
          MAB: begin
            if (space) begin
              if (cnt >= CW'(MAB_MIN)) begin
                state    <= START;
                cnt      <= CW'(1);
                from_mab <= 1'b1;
                cur_idx  <= '0;
              end else begin
                error <= 1'b1;
                state <= WAIT_BREAK;
              end
            end else if (cnt < CW'(MAB_MIN)) begin
              cnt <= cnt + 1'b1;
            end
          end
          IDLE: begin
            if (space) begin
              state    <= START;
              cnt      <= CW'(1);
              from_mab <= 1'b0;
            end
          end
          START: begin
            if (cnt == CW'(HALF)) begin
              cnt <= '0;
              if (space) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                state <= from_mab ? WAIT_BREAK : IDLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            if (cnt == CW'(OVERSAMPLE - 1)) begin
              cnt     <= '0;
              shreg   <= {~space, shreg[7:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) state <= STOP1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STOP1: begin
            if (cnt == CW'(OVERSAMPLE - 1)) begin
              cnt <= '0;
              if (!space) begin
                state <= STOP2;
              end else if (spc_cnt >= SW'(RUN9)) begin
                // Line space since the start edge: a break is
                // probably under way, let break detection decide.
                state <= WAIT_BREAK;
              end else begin
                error <= 1'b1;
                open  <= 1'b0;
                state <= WAIT_BREAK;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STOP2: begin
            if (cnt == CW'(OVERSAMPLE - 1)) begin
              cnt <= '0;
              if (space) begin
                error <= 1'b1;
                open  <= 1'b0;
                state <= WAIT_BREAK;
              end else begin
                state <= IDLE;
                if (cur_idx == 10'd0) begin
                  slot_valid  <= 1'b1;
                  frame_start <= 1'b1;
                  slot_index  <= '0;
                  slot_data   <= shreg;
                  open        <= 1'b1;
                  cur_idx     <= 10'd1;
                end else if (open) begin
                  slot_valid <= 1'b1;
                  slot_index <= cur_idx;
                  slot_data  <= shreg;
                  cur_idx    <= cur_idx + 10'd1;
                  if (cur_idx == 10'd512) begin
                    frame_end  <= 1'b1;
                    slot_count <= 10'd512;
                    open       <= 1'b0;
                  end
                end
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmx_rx.sv
// Scoreboard bench for dmx_rx: INVERT=1 and INVERT=0 instances
// driven with the same normalised line, outputs cross-compared.
module tb_dmx_rx;

  localparam int OS   = 4;
  localparam int BRK  = 88;
  localparam int MABM = 8;

  typedef struct {
    logic       sv;
    logic [9:0] idx;
    logic [7:0] data;
    logic       fs;
    logic       fe;
    logic [9:0] cnt;
    logic       err;
  } ev_t;

  logic       dmxclk = 1'b0;
  logic       rst;
  logic       rx1, rx0;
  logic       slot_valid, frame_start, frame_end, error;
  logic [9:0] slot_index, slot_count;
  logic [7:0] slot_data;
  logic       sv0, fs0, fe0, er0;
  logic [9:0] si0, sc0;
  logic [7:0] sd0;

  int checks = 0;
  int failures = 0;
  ev_t exp_q[$];

  always #5 dmxclk = ~dmxclk;

  dmx_rx #(
    .OVERSAMPLE(OS), .BREAK_MIN(BRK),
    .MAB_MIN(MABM), .INVERT(1'b1)
  ) dut (
    .dmxclk(dmxclk), .rst(rst), .rx(rx1),
    .slot_valid(slot_valid), .slot_index(slot_index),
    .slot_data(slot_data), .frame_start(frame_start),
    .frame_end(frame_end), .slot_count(slot_count),
    .error(error)
  );

  dmx_rx #(
    .OVERSAMPLE(OS), .BREAK_MIN(BRK),
    .MAB_MIN(MABM), .INVERT(1'b0)
  ) dut0 (
    .dmxclk(dmxclk), .rst(rst), .rx(rx0),
    .slot_valid(sv0), .slot_index(si0),
    .slot_data(sd0), .frame_start(fs0),
    .frame_end(fe0), .slot_count(sc0),
    .error(er0)
  );

  // Scoreboard pop and INVERT cross-check, away from the rising edge.
  always @(negedge dmxclk) begin
    ev_t e;
    logic [31:0] o1, o0;
    o1 = {slot_valid, slot_index, slot_data, frame_start,
          frame_end, slot_count, error};
    o0 = {sv0, si0, sd0, fs0, fe0, sc0, er0};
    checks++;
    if (o1 !== o0) begin
      failures++;
      $display("FAIL invert_match inv1=%h inv0=%h", o1, o0);
    end
    if (slot_valid || frame_start || frame_end || error) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event sv=%b idx=%0d fs=%b fe=%b err=%b",
                 slot_valid, slot_index, frame_start, frame_end, error);
      end else begin
        e = exp_q.pop_front();
        if (slot_valid !== e.sv || frame_start !== e.fs ||
            frame_end !== e.fe || error !== e.err ||
            (e.sv && (slot_index !== e.idx ||
                      slot_data !== e.data)) ||
            (e.fe && slot_count !== e.cnt)) begin
          failures++;
          $display("FAIL event got sv=%b idx=%0d d=%h fs=%b fe=%b cnt=%0d err=%b exp sv=%b idx=%0d d=%h fs=%b fe=%b cnt=%0d err=%b",
                   slot_valid, slot_index, slot_data, frame_start,
                   frame_end, slot_count, error, e.sv, e.idx,
                   e.data, e.fs, e.fe, e.cnt, e.err);
        end
      end
    end
  end

  task automatic push_ev(input logic sv, input int idx,
                         input int data, input logic fs,
                         input logic fe, input int cnt,
                         input logic err);
    ev_t e;
    e.sv = sv; e.idx = 10'(idx); e.data = 8'(data);
    e.fs = fs; e.fe = fe; e.cnt = 10'(cnt); e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic line(input bit sp, input int n);
    rx1 = sp;
    rx0 = ~sp;
    repeat (n) @(negedge dmxclk);
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input bit bad_stop1);
    line(1'b1, OS);
    for (int k = 0; k < 8; k++) line(~b[k], OS);
    line(bad_stop1, OS);
    line(1'b0, OS);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge dmxclk);
    rst = 1'b0;
    line(1'b0, 5);
  endtask

  task automatic drain(input string name);
    line(1'b0, 20);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_pending left=%0d required=0",
               name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx1 = 1'b0;
    rx0 = 1'b1;
    repeat (3) @(negedge dmxclk);
    checks += 3;
    if (slot_valid !== 1'b0 || frame_start !== 1'b0 ||
        frame_end !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulses sv=%b fs=%b fe=%b err=%b req 0",
               slot_valid, frame_start, frame_end, error);
    end
    if (slot_index !== 10'd0 || slot_data !== 8'd0) begin
      failures++;
      $display("FAIL reset_slot idx=%0d d=%h req 0",
               slot_index, slot_data);
    end
    if (slot_count !== 10'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d req=0", slot_count);
    end
    rst = 1'b0;
    line(1'b0, 10);
  endtask

  task automatic test_basic_frame();
    do_reset();
    line(1'b1, 100);
    line(1'b0, MABM);
    for (int i = 0; i < 4; i++) begin
      push_ev(1, i, i, i == 0, 0, 0, 0);
      send_byte(8'(i), 1'b0);
    end
    push_ev(0, 0, 0, 0, 1, 3, 0);
    line(1'b1, 100);
    line(1'b0, 4);
    drain("basic");
    checks += 2;
    if (slot_count !== 10'd3) begin
      failures++;
      $display("FAIL basic_count got=%0d req=3", slot_count);
    end
    if (slot_index !== 10'd3 || slot_data !== 8'h03) begin
      failures++;
      $display("FAIL basic_hold idx=%0d d=%h req 3/03",
               slot_index, slot_data);
    end
  endtask

  task automatic test_short_break();
    do_reset();
    line(1'b1, 75);
    line(1'b0, MABM);
    for (int i = 0; i < 3; i++) send_byte(8'(i + 8'h20), 1'b0);
    line(1'b0, 10);
    drain("short_break");
  endtask

  task automatic test_short_mab();
    do_reset();
    line(1'b1, 100);
    line(1'b0, MABM - 1);
    push_ev(0, 0, 0, 0, 0, 0, 1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    line(1'b1, 100);
    line(1'b0, MABM);
    push_ev(1, 0, 8'h33, 1, 0, 0, 0);
    send_byte(8'h33, 1'b0);
    push_ev(0, 0, 0, 0, 1, 0, 0);
    line(1'b1, 100);
    line(1'b0, 4);
    drain("short_mab");
  endtask

  task automatic test_stop_error();
    do_reset();
    line(1'b1, 100);
    line(1'b0, MABM);
    push_ev(1, 0, 8'h10, 1, 0, 0, 0);
    send_byte(8'h10, 1'b0);
    push_ev(1, 1, 8'h11, 0, 0, 0, 0);
    send_byte(8'h11, 1'b0);
    push_ev(0, 0, 0, 0, 1, 1, 0);
    line(1'b1, 100);
    line(1'b0, MABM);
    push_ev(1, 0, 8'hA0, 1, 0, 0, 0);
    send_byte(8'hA0, 1'b0);
    push_ev(1, 1, 8'hA1, 0, 0, 0, 0);
    send_byte(8'hA1, 1'b0);
    push_ev(0, 0, 0, 0, 0, 0, 1);
    send_byte(8'hA2, 1'b1);
    send_byte(8'hA3, 1'b0);
    line(1'b1, 100);
    line(1'b0, 4);
    drain("stop_err");
    checks++;
    if (slot_count !== 10'd1) begin
      failures++;
      $display("FAIL stop_err_count got=%0d req=1", slot_count);
    end
  endtask

  task automatic test_max_slots();
    do_reset();
    line(1'b1, 100);
    line(1'b0, MABM);
    for (int i = 0; i < 514; i++) begin
      if (i <= 512) push_ev(1, i, i & 255, i == 0, i == 512, 512, 0);
      send_byte(8'(i), 1'b0);
    end
    line(1'b1, 100);
    line(1'b0, 4);
    drain("max_slots");
    checks += 2;
    if (slot_count !== 10'd512) begin
      failures++;
      $display("FAIL max_count got=%0d req=512", slot_count);
    end
    if (slot_index !== 10'd512) begin
      failures++;
      $display("FAIL max_last_idx got=%0d req=512", slot_index);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    line(1'b1, 100);
    line(1'b0, MABM);
    for (int i = 0; i < 3; i++) begin
      push_ev(1, i, 8'h40 + i, i == 0, 0, 0, 0);
      send_byte(8'(8'h40 + i), 1'b0);
    end
    push_ev(0, 0, 0, 0, 1, 2, 0);
    line(1'b1, 100);
    line(1'b0, MABM);
    for (int i = 0; i < 5; i++) begin
      push_ev(1, i, 8'h50 + i, i == 0, 0, 0, 0);
      send_byte(8'(8'h50 + i), 1'b0);
    end
    line(1'b1, OS);
    line(1'b0, 6);
    #3 rst = 1'b1;
    #1;
    checks += 3;
    if (slot_count !== 10'd0) begin
      failures++;
      $display("FAIL mid_rst_count got=%0d req=0", slot_count);
    end
    if (slot_index !== 10'd0 || slot_data !== 8'd0) begin
      failures++;
      $display("FAIL mid_rst_slot idx=%0d d=%h req 0",
               slot_index, slot_data);
    end
    if (slot_valid !== 1'b0 || error !== 1'b0 ||
        frame_end !== 1'b0 || frame_start !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_pulses sv=%b err=%b fe=%b fs=%b req 0",
               slot_valid, error, frame_end, frame_start);
    end
    @(negedge dmxclk);
    rst = 1'b0;
    line(1'b0, 3 * OS);
    for (int i = 6; i < 9; i++) send_byte(8'(8'h50 + i), 1'b0);
    drain("mid_rst");
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_short_break();
    test_short_mab();
    test_stop_error();
    test_max_slots();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmx_rx.md
DMX_RX -- requirements
Module: dmx_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16: dmxclk cycles per DMX bit (dmxclk = 4 MHz for 250 kbit/s).
REQ-002 SHALL have parameter BREAK_MIN, default 352: minimum consecutive space-level cycles recognised as a break (22 bit times).
REQ-003 SHALL have parameter MAB_MIN, default 32: minimum mark-level cycles after a break before the start code's start bit (8 us).
REQ-004 SHALL have parameter INVERT, default 1: 1 = rx high is space/break level, the team's transmitter line polarity; 0 = rx low is space.
REQ-005 dmxclk  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 rx  input  1  asynchronous DMX line.
REQ-008 slot_valid  output  1  one-cycle strobe: slot_index/slot_data valid.
REQ-009 slot_index  output  10  0 = start code, 1..512 = channel slots.
REQ-010 slot_data  output  8  received byte, LSB first on the wire.
REQ-011 frame_start  output  1  one-cycle pulse when the start code (slot 0) is accepted.
REQ-012 frame_end  output  1  one-cycle pulse, at most once per frame.
REQ-013 slot_count  output  10  channel slots in the last completed frame (0..512).
REQ-014 error  output  1  one-cycle pulse on MAB or framing violation.

Function
REQ-015 rx SHALL pass through a 2-flop synchroniser, then be normalised per INVERT to a mark/space level; all timing below uses the normalised signal.
REQ-016 A space-run counter SHALL count consecutive space cycles, saturate at BREAK_MIN, and clear on any mark cycle.
REQ-017 States: WAIT_BREAK, BREAK, MAB, IDLE, START, DATA, STOP1, STOP2.
REQ-018 Counter reaching BREAK_MIN SHALL force BREAK from any state; if a frame was open (start code accepted, frame_end not yet pulsed) frame_end SHALL pulse and slot_count SHALL load the channel slots received.
REQ-019 BREAK -> MAB on first mark cycle; MAB counts mark cycles; space with count < MAB_MIN -> error pulse, WAIT_BREAK; space with count >= MAB_MIN -> START, slot index 0.
REQ-020 IDLE -> START on first space cycle; START re-samples at cycle OVERSAMPLE/2-1 from edge; mark there = glitch -> IDLE (MAB-derived start -> WAIT_BREAK), no error.
REQ-021 DATA SHALL sample 8 bits at OVERSAMPLE-cycle intervals from the start-bit mid-sample, shifting LSB first.
REQ-022 STOP1/STOP2 sample at further OVERSAMPLE intervals; space at either -> error pulse, slot discarded, frame aborted (no frame_end, slot_count unchanged), WAIT_BREAK.
REQ-023 Both stop bits mark -> slot_valid SHALL assert the cycle after the STOP2 sample with slot_index/slot_data; state -> IDLE; index increments.
REQ-024 Slot 0 SHALL be emitted regardless of start-code value; frame_start pulses same cycle.
REQ-025 Completion of slot 512 SHALL pulse frame_end with slot_count = 512 in the same cycle; slots 513+ SHALL be received but not emitted, no error.
REQ-026 Break-detection frame_end and slot-512 frame_end SHALL not both occur for one frame.
REQ-027 slot_index/slot_data SHALL hold between strobes; WAIT_BREAK ignores all traffic until a break.

Reset
REQ-028 rst SHALL immediately force: state WAIT_BREAK, synchroniser flops to mark level, all counters 0, all outputs 0.
REQ-029 After rst release, slots SHALL be emitted only after a complete break + valid MAB; reset mid-frame discards the partial frame.

Verification
REQ-030 Break 400, MAB 32, bytes 0x00,0x01,0x02,0x03, break -> 4 strobes index 0..3 data 00..03; frame_start once; frame_end at second break; slot_count = 3.
REQ-031 Break 300 cycles then valid MAB/slots -> no slot_valid, no frame_start.
REQ-032 Break 400, MAB 16 -> error pulse at start-bit edge; no strobes until next valid break.
REQ-033 Slot 2 with STOP1 at space -> slots 0,1 emitted, error pulse, no slot 2, no frame_end; slot_count keeps prior value.
REQ-034 513 channel slots -> frame_end with slot 512 strobe, slot_count = 512, no strobe for slot 513, no second frame_end at next break.
REQ-035 rst pulse mid-slot 5 -> outputs 0 asynchronously; following slots without a break -> no strobes; INVERT=0 repeat of REQ-030 with inverted rx -> identical outputs.
